// File: rtl/fetch_stage.sv
// PC register and IF/ID pipeline register for the RV32I fetch stage.
// Optional saturating perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                  PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 8'h00,
    parameter logic [31:0]         NOP_INSTR = 32'h00000013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic                ifid_valid,
    output logic [31:0]         ifid_instr,
    output logic [PC_WIDTH-1:0] ifid_pc,
    output logic [PC_WIDTH-1:0] ifid_pc_plus4,
    output logic                misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]         perf_fetched,
    output logic [15:0]         perf_bubbles
`endif
);

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next_seq;
    logic                load_valid;
    logic                load_bubble;

    assign imem_addr   = pc;
    assign pc_next_seq = pc + PC_WIDTH'(4);

    // Redirect outranks flush, which outranks stall; anything else advances.
    always_comb begin
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        if (redirect_valid || flush) begin
            load_bubble = 1'b1;
        end else if (!stall) begin
            load_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            ifid_valid    <= 1'b0;
            ifid_instr    <= NOP_INSTR;
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
            misalign_err  <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
            if (redirect_valid) begin
                pc <= {redirect_target[PC_WIDTH-1:2], 2'b00};
            end else if (load_valid) begin
                pc <= pc_next_seq;
            end
            if (load_bubble) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_INSTR;
            end else if (load_valid) begin
                ifid_valid    <= 1'b1;
                ifid_instr    <= imem_rdata;
                ifid_pc       <= pc;
                ifid_pc_plus4 <= pc_next_seq;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (load_valid && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 16'd1;
            end
            if (load_bubble && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random control
// traffic, compared against a cycle-level behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic [7:0]  ifid_pc_plus4;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_bubbles;
    int          m_fet;
    int          m_bub;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_pc;
    int          m_valid;
    logic [31:0] m_instr;
    int          m_ipc;
    int          m_ipc4;
    int          m_mis;

    always #5 clk = ~clk;

    assign imem_rdata = {24'hA50000, imem_addr};

    fetch_stage #(
        .PC_WIDTH (8),
        .RESET_PC (8'h00),
        .NOP_INSTR(32'h00000013)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .misalign_err   (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("imem_addr", {24'h0, imem_addr}, 32'(m_pc));
        check("ifid_valid", {31'h0, ifid_valid}, 32'(m_valid));
        check("ifid_instr", ifid_instr, m_instr);
        check("ifid_pc", {24'h0, ifid_pc}, 32'(m_ipc));
        check("ifid_pc_plus4", {24'h0, ifid_pc_plus4}, 32'(m_ipc4));
        check("misalign_err", {31'h0, misalign_err}, 32'(m_mis));
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", {16'h0, perf_fetched}, 32'(m_fet));
        check("perf_bubbles", {16'h0, perf_bubbles}, 32'(m_bub));
`endif
    endtask

    // One clock: apply controls, advance the model by the documented priority, compare.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic rv, input logic [7:0] rt);
        reset = r; stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
        @(posedge clk);
        if (r) begin
            m_pc = 0; m_valid = 0; m_instr = 32'h13; m_ipc = 0; m_ipc4 = 0; m_mis = 0;
`ifdef FETCH_PERF_CNT_EN
            m_fet = 0; m_bub = 0;
`endif
        end else begin
            m_mis = (rv && (int'(rt) % 4 != 0)) ? 1 : 0;
            if (rv || f) begin
                if (rv) m_pc = int'(rt) - (int'(rt) % 4);
                m_valid = 0;
                m_instr = 32'h13;
`ifdef FETCH_PERF_CNT_EN
                if (m_bub < 65535) m_bub++;
`endif
            end else if (!s) begin
                m_valid = 1;
                m_instr = 32'hA5000000 + 32'(m_pc);
                m_ipc   = m_pc;
                m_ipc4  = (m_pc + 4) % 256;
                m_pc    = (m_pc + 4) % 256;
`ifdef FETCH_PERF_CNT_EN
                if (m_fet < 65535) m_fet++;
`endif
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_target = 8'h00;

        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        check("reset_valid", {31'h0, ifid_valid}, 32'h0);
        check("reset_instr", ifid_instr, 32'h00000013);

        step(0, 0, 0, 0, 8'h00);
        check("first_pc", {24'h0, ifid_pc}, 32'h00);
        check("first_instr", ifid_instr, 32'hA5000000);
        step(0, 0, 0, 0, 8'h00);
        check("second_instr", ifid_instr, 32'hA5000004);

        // Stall three cycles with pc=08
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 8'h00);
            check("stall_addr", {24'h0, imem_addr}, 32'h08);
            check("stall_ifid_pc", {24'h0, ifid_pc}, 32'h04);
        end
        step(0, 0, 0, 0, 8'h00);
        check("stall_release", {24'h0, ifid_pc}, 32'h08);
        step(0, 0, 0, 0, 8'h00);

        // Redirect to 0x30 from pc=0x10
        check("pre_redirect_pc", {24'h0, imem_addr}, 32'h10);
        step(0, 0, 0, 1, 8'h30);
        check("redir_bubble", ifid_instr, 32'h00000013);
        step(0, 0, 0, 0, 8'h00);
        check("redir_target_instr", ifid_instr, 32'hA5000030);

        // Misaligned redirect, also with stall+flush asserted
        step(0, 1, 1, 1, 8'h33);
        check("misalign_pc", {24'h0, imem_addr}, 32'h30);
        check("misalign_pulse", {31'h0, misalign_err}, 32'h1);
        step(0, 0, 0, 0, 8'h00);
        check("misalign_clear", {31'h0, misalign_err}, 32'h0);

        // Flush alone, then stall+flush
        step(0, 0, 1, 0, 8'h00);
        step(0, 1, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // Wrap-around
        step(0, 0, 0, 1, 8'hFC);
        step(0, 0, 0, 0, 8'h00);
        check("wrap_pc", {24'h0, ifid_pc}, 32'hFC);
        check("wrap_pc4", {24'h0, ifid_pc_plus4}, 32'h00);
        step(0, 0, 0, 0, 8'h00);
        check("wrap_next", {24'h0, ifid_pc}, 32'h00);

        // Reset mid-run while stall and redirect are active
        step(1, 1, 0, 1, 8'h44);
        check("midreset_pc", {24'h0, imem_addr}, 32'h00);
        check("midreset_valid", {31'h0, ifid_valid}, 32'h0);

        // Random control traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 50) == 0, ($urandom % 5) == 0, ($urandom % 8) == 0,
                 ($urandom % 10) == 0, 8'($urandom % 256));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register plus IF/ID pipeline register for the RV32I core.
- Drives the 8-bit byte address into the combinational instruction memory and captures the returned 32-bit word with its PC for decode.
- Supports stall (decode back-pressure), redirect (taken branch/jump from execute) and flush, inserting canonical NOP bubbles.

Parameters:
- PC_WIDTH, 8, width of PC and instruction-memory address.
- RESET_PC, 8'h00, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction word presented on a bubble (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- flush  input  1  squash IF/ID contents (bubble) this cycle.
- redirect_valid  input  1  load PC from redirect_target.
- redirect_target  input  PC_WIDTH  new fetch address.
- imem_addr  output  PC_WIDTH  address to instruction memory; equals current PC (combinational).
- imem_rdata  input  32  instruction word from memory, valid same cycle as imem_addr.
- ifid_valid  output  1  IF/ID slot holds a real instruction.
- ifid_instr  output  32  latched instruction, or NOP_INSTR when invalid.
- ifid_pc  output  PC_WIDTH  PC of ifid_instr.
- ifid_pc_plus4  output  PC_WIDTH  ifid_pc+4, modulo 2^PC_WIDTH.
- misalign_err  output  1  one-cycle pulse: redirect_target[1:0] was nonzero.

Behaviour:
- All state updates on rising clk edge. Priority: reset > redirect_valid > flush > stall > normal advance.
- Reset (synchronous; also mid-operation): pc=RESET_PC; ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=0, misalign_err=0. First real instruction appears on IF/ID one edge after reset deasserts.
- Normal (no reset/redirect/flush/stall):
  - IF/ID <= {valid=1, instr=imem_rdata, pc=pc, pc_plus4=pc+4}.
  - pc <= pc+4.
  - Latency one cycle from address to ifid_instr.
- Wrap-around: pc+4 truncated to PC_WIDTH; e.g. 8'hFC advances to 8'h00, and ifid_pc_plus4 for 8'hFC is 8'h00.
- Stall: pc and all IF/ID registers hold; imem_addr stays constant.
- Flush without redirect: IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc/pc_plus4 hold). pc holds, so the squashed word is refetched next cycle.
- Redirect:
  - pc <= {redirect_target[PC_WIDTH-1:2],2'b00}.
  - IF/ID <= bubble, since the word fetched this cycle is wrong-path.
  - Overrides simultaneous stall and flush.
- misalign_err: registered; 1 on the cycle after a redirect with nonzero target[1:0], else 0. Redirect still taken with alignment forced.
- pc[1:0] is always 2'b00.
- Stall+flush together: flush wins (bubble, pc holds).
- Outputs are registered except imem_addr.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[15:0] and perf_bubbles[15:0].
  - perf_fetched increments on each edge where IF/ID loads a valid instruction.
  - perf_bubbles increments on each edge where IF/ID loads a bubble (flush/redirect).
  - Stall cycles are not counted.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Memory stub RD={24'hA50000,addr}; reset 2 cycles then run 4 cycles -> ifid_pc 00,04,08,0C with ifid_instr A5000000,A5000004,A5000008,A500000C, valid=1 after first edge.
- stall held 3 cycles at pc=08 -> imem_addr stays 08, ifid_pc stays 04; release -> ifid_pc=08 next edge.
- redirect_valid with target=8'h30 at pc=10 -> next edge ifid_valid=0, ifid_instr=00000013; following edge ifid_pc=30, ifid_instr=A5000030.
- redirect target=8'h33 -> pc=30, misalign_err=1 for exactly one cycle.
- Force pc to FC via redirect, run 2 cycles -> ifid_pc=FC, ifid_pc_plus4=00, then ifid_pc=00.
- reset asserted mid-run with stall=1 and redirect_valid=1 -> pc=00, ifid_valid=0. With FETCH_PERF_CNT_EN, counters read 0 after reset and count 4 fetched / 1 bubble in the redirect scenario.
